// File: rtl/clfsr_keystream_ctrl.sv
// clfsr_keystream_ctrl: seed load, warm-up and MSB-first word packing for the chaotic LFSR core.
// Optional run-length health test is compiled in when CLFSR_HEALTH_EN is defined.
module clfsr_keystream_ctrl #(
   parameter int SEED_W    = 32,
   parameter int WORD_W    = 8,
   parameter int WARMUP    = 64,
   parameter int REP_LIMIT = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [SEED_W-1:0] seed,
   output logic              busy,
   output logic              core_load,
   output logic [SEED_W-1:0] core_seed,
   output logic              core_en,
   input  logic              core_bit,
   output logic [WORD_W-1:0] kw_data,
   output logic              kw_valid,
   input  logic              kw_ready,
   output logic              fault
);

   localparam int CW = $clog2(WORD_W);
   localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

`ifdef CLFSR_HEALTH_EN
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WARM, S_RUN, S_FAULT
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_LOAD, S_WARM, S_RUN
   } state_t;
`endif

   state_t            state, nxt;
   logic [WW-1:0]     wcnt;
   logic [CW-1:0]     cnt;
   logic [WORD_W-2:0] acc;
   logic [WORD_W-1:0] shifted;
   logic              word_last;
   logic              stall;
   logic              consume;
   logic              warm_done;
   logic              rep_hit;

   assign shifted   = {acc, core_bit};
   assign word_last = (cnt == CW'(WORD_W - 1));
   // last bit of a word waits while the previous word is still unaccepted
   assign stall     = word_last && kw_valid && !kw_ready;
   assign consume   = (state == S_RUN) && !stall;
   assign warm_done = (wcnt == WW'(WARMUP - 1));
   assign busy      = (state != S_IDLE);

`ifdef CLFSR_HEALTH_EN
   localparam int RW = $clog2(REP_LIMIT + 1);
   logic [RW-1:0] rl;
   logic [RW-1:0] rl_nxt;
   logic          fault_q;

   // run length of identical consumed bits; zero means no bit seen yet
   always_comb begin
      rl_nxt = RW'(1);
      if (rl != '0 && core_bit == acc[0])
         rl_nxt = rl + 1'b1;
   end

   assign rep_hit = consume && (rl_nxt == RW'(REP_LIMIT));
   assign fault   = fault_q;

   // health state: run length and sticky fault flag
   always_ff @(posedge clk) begin
      if (rst) begin
         rl      <= '0;
         fault_q <= 1'b0;
      end else begin
         if (state == S_LOAD)
            rl <= '0;
         else if (consume && !stop)
            rl <= rl_nxt;
         if (rep_hit && !stop)
            fault_q <= 1'b1;
         else if (state == S_FAULT && start)
            fault_q <= 1'b0;
      end
   end
`else
   assign rep_hit = 1'b0;
   assign fault   = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= nxt;
   end

   // next state and core strobes
   always_comb begin
      nxt       = state;
      core_en   = 1'b0;
      core_load = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start && !stop)
               nxt = S_LOAD;
         end
         S_LOAD: begin
            core_load = 1'b1;
            nxt       = stop ? S_IDLE : S_WARM;
         end
         S_WARM: begin
            core_en = 1'b1;
            if (stop)
               nxt = S_IDLE;
            else if (warm_done)
               nxt = S_RUN;
         end
         S_RUN: begin
            core_en = !stall;
            if (stop)
               nxt = S_IDLE;
`ifdef CLFSR_HEALTH_EN
            else if (rep_hit)
               nxt = S_FAULT;
         end
         S_FAULT: begin
            if (start)
               nxt = S_LOAD;
`endif
         end
         default: nxt = S_IDLE;
      endcase
   end

   // seed capture, warm-up count, bit packing and word handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         core_seed <= '0;
         wcnt      <= '0;
         cnt       <= '0;
         acc       <= '0;
         kw_data   <= '0;
         kw_valid  <= 1'b0;
      end else begin
         if (kw_valid && kw_ready)
            kw_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start && !stop)
                  core_seed <= seed;
            end
            S_LOAD: begin
               wcnt <= '0;
               cnt  <= '0;
            end
            S_WARM: begin
               wcnt <= wcnt + 1'b1;
            end
            S_RUN: begin
               if (stop) begin
                  kw_valid <= 1'b0;
                  cnt      <= '0;
               end else if (rep_hit) begin
                  kw_valid <= 1'b0;
               end else if (consume) begin
                  acc <= shifted[WORD_W-2:0];
                  if (word_last) begin
                     cnt      <= '0;
                     kw_data  <= shifted;
                     kw_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
`ifdef CLFSR_HEALTH_EN
            S_FAULT: begin
               if (start)
                  core_seed <= seed;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
